// File: rtl/logic_gate_pipe.sv
// Registered bitwise logic unit with valid/ready handshake and a DEPTH-entry result FIFO.
// Optional feature macro GATE_STATS_EN adds a saturating OP_COUNT accept counter port.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO
`ifdef GATE_STATS_EN
    ,
    output logic [15:0]      OP_COUNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [WIDTH-1:0] y_mem [DEPTH];
    logic             z_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    always_comb begin
        result = '0;
        case (op_e'(OP))
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_NAND: result = ~(A & B);
            OP_NOR:  result = ~(A | B);
            OP_XNOR: result = ~(A ^ B);
            OP_NOTA: result = ~A;
            OP_PASS: result = A;
            default: result = '0;
        endcase
    end

    // Ready depends on registered count only, so a pop cannot make room for a push in the same cycle.
    assign IN_READY  = (count != CW'(DEPTH));
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign Y         = OUT_VALID ? y_mem[rd_ptr] : '0;
    assign ZERO      = OUT_VALID ? z_mem[rd_ptr] : 1'b0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                y_mem[i] <= '0;
                z_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                y_mem[wr_ptr] <= result;
                z_mem[wr_ptr] <= (result == '0);
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef GATE_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OP_COUNT <= '0;
        end else if (push && (OP_COUNT != 16'hFFFF)) begin
            OP_COUNT <= OP_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: constant vector table, directed FIFO corner cases,
// and random traffic scored against a queue-based reference model.
module tb_logic_gate_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [2:0]       OP = '0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [WIDTH-1:0] Y;
    logic             ZERO;
`ifdef GATE_STATS_EN
    logic [15:0]      OP_COUNT;
`endif

    logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
        .ZERO      (ZERO)
`ifdef GATE_STATS_EN
        ,
        .OP_COUNT  (OP_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
    } vec_t;

    vec_t        tbl [10];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [7:0]  q [$];
    bit          hold_valid = 1'b0;
    logic [7:0]  hold_y = '0;
    int unsigned op_cnt = 0;
    bit          acc;
    bit          tg;
    int          guard;
    int          k;
    logic [7:0]  order_exp [3];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bitwise ops expressed as complements by subtraction from all-ones.
    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return 8'hFF - (a & b);
            3'd4:    return 8'hFF - (a | b);
            3'd5:    return 8'hFF - (a ^ b);
            3'd6:    return 8'hFF - a;
            default: return a;
        endcase
    endfunction

    task automatic cycle(output bit accepted);
        bit popped;
        check("in_ready", 32'(IN_READY), 32'(q.size() != DEPTH));
        check("out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
        check("y", 32'(Y), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check("zero", 32'(ZERO), 32'(q.size() != 0 && q[0] == 8'h00));
        if (hold_valid) check("y_stable", 32'(Y), 32'(hold_y));
`ifdef GATE_STATS_EN
        check("op_count", 32'(OP_COUNT), op_cnt);
`endif
        hold_valid = (q.size() != 0) && !OUT_READY;
        hold_y     = (q.size() != 0) ? q[0] : 8'h00;
        accepted   = IN_VALID && (q.size() < DEPTH);
        popped     = OUT_READY && (q.size() != 0);
        @(posedge CLK);
        if (popped) void'(q.pop_front());
        if (accepted) begin
            q.push_back(ref_op(OP, A, B));
            if (op_cnt < 65535) op_cnt++;
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        hold_valid = 1'b0;
        op_cnt = 0;
    endtask

    initial begin
        tbl[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[1] = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        tbl[2] = '{3'd2, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        tbl[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0};
        tbl[4] = '{3'd4, 8'hF0, 8'h3C, 8'h03, 1'b0};
        tbl[5] = '{3'd5, 8'hF0, 8'h3C, 8'h33, 1'b0};
        tbl[6] = '{3'd6, 8'hF0, 8'h3C, 8'h0F, 1'b0};
        tbl[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0};
        tbl[8] = '{3'd2, 8'hAA, 8'hAA, 8'h00, 1'b1};
        tbl[9] = '{3'd1, 8'hAA, 8'hAA, 8'hAA, 1'b0};
        order_exp[0] = 8'h30;
        order_exp[1] = 8'hFC;
        order_exp[2] = 8'hCC;

        // Reset state
        #12;
        check("rst_out_valid", 32'(OUT_VALID), 0);
        check("rst_y", 32'(Y), 0);
        check("rst_zero", 32'(ZERO), 0);
        check("rst_in_ready", 32'(IN_READY), 1);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Table: back-to-back ops, result visible one cycle after accept
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            OP = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
            cycle(acc);
            check("tbl_accept", 32'(acc), 1);
            check("tbl_valid", 32'(OUT_VALID), 1);
            check("tbl_y", 32'(Y), 32'(tbl[i].y));
            check("tbl_zero", 32'(ZERO), 32'(tbl[i].z));
        end
        IN_VALID = 1'b0;
        cycle(acc);
        cycle(acc);

        // Backpressure: third op held while full, then order 1,2,3
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        A = 8'hF0; B = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            OP = 3'(i);
            cycle(acc);
            check("bp_accept", 32'(acc), 1);
        end
        OP = 3'd2;
        repeat (2) begin
            check("bp_full_ready", 32'(IN_READY), 0);
            cycle(acc);
            check("bp_no_capture", 32'(acc), 0);
        end
        OUT_READY = 1'b1;
        k = 0;
        guard = 0;
        while (k < 3 && guard < 20) begin
            if (OUT_VALID && k < 3) begin
                check("bp_order", 32'(Y), 32'(order_exp[k]));
                k++;
            end
            cycle(acc);
            if (acc) IN_VALID = 1'b0;
            guard++;
        end
        if (k < 3) check("bp_timeout", 0, 1);
        check("bp_drained", 32'(OUT_VALID), 0);

        // Stream 10 ops with toggling OUT_READY across repeated wrap
        tg = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1;
            OP = 3'($urandom_range(0, 7));
            A  = 8'($urandom);
            B  = 8'($urandom);
            guard = 0;
            do begin
                OUT_READY = tg;
                tg = ~tg;
                cycle(acc);
                guard++;
            end while (!acc && guard < 20);
            if (!acc) check("stream_timeout", 0, 1);
        end
        IN_VALID = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            OUT_READY = tg;
            tg = ~tg;
            cycle(acc);
            guard++;
        end
        check("stream_drained", 32'(OUT_VALID), 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            IN_VALID  = 1'($urandom);
            OUT_READY = 1'($urandom);
            OP = 3'($urandom);
            A  = 8'($urandom);
            B  = 8'($urandom);
            cycle(acc);
        end

        // Reset while full: outputs clear immediately, nothing stale afterwards
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        guard = 0;
        while (q.size() != DEPTH && guard < 20) begin
            OP = 3'd7; A = 8'h5A;
            cycle(acc);
            guard++;
        end
        check("full_before_reset", 32'(IN_READY), 0);
        IN_VALID = 1'b0;
        #3 RST_N = 1'b0;
        #1;
        check("midrst_out_valid", 32'(OUT_VALID), 0);
        check("midrst_y", 32'(Y), 0);
        check("midrst_zero", 32'(ZERO), 0);
        check("midrst_in_ready", 32'(IN_READY), 1);
        model_reset();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        repeat (3) cycle(acc);

`ifdef GATE_STATS_EN
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            OP = 3'(i); A = 8'($urandom); B = 8'($urandom);
            cycle(acc);
        end
        IN_VALID = 1'b0;
        cycle(acc);
        check("op_count_5", 32'(OP_COUNT), 5);
        IN_VALID = 1'b1;
        repeat (65540) @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check("op_count_sat", 32'(OP_COUNT), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
